// File: rtl/decode_pkg.sv
// Shared opcode constants and the decoded-field bundle for the decode stage.
// Used by decode_fields and instr_decode_stage.
package decode_pkg;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        funct1;
      logic [11:0] imm12;
      logic [19:0] u_imm20;
      logic        illegal;
   } decoded_fields_t;

endpackage

// File: rtl/decode_fields.sv
// Combinational RV32I field splitter: raw instruction -> decoded_fields_t.
// ILLEGAL_CHK=0 ties the illegal flag low.
import decode_pkg::*;

module decode_fields #(
   parameter bit ILLEGAL_CHK = 1'b1
) (
   input  logic [31:0]     instr,
   output decoded_fields_t fields
);

   logic [6:0] opc;
   logic       legal;

   assign opc = instr[6:0];

   always_comb begin
      unique case (opc)
         OP_IMM, OP_REG, OP_STORE, OP_LOAD, OP_LUI,
         OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
         OP_SYSTEM: legal = 1'b1;
         default:   legal = 1'b0;
      endcase
   end

   always_comb begin
      fields         = '0;
      fields.opcode  = opc;
      fields.rd      = instr[11:7];
      fields.funct3  = instr[14:12];
      fields.rs1     = instr[19:15];
      fields.rs2     = instr[24:20];
      fields.funct1  = instr[30];
      fields.u_imm20 = instr[31:12];
      // stores split their offset around the rd slot
      if (opc == OP_STORE)
         fields.imm12 = {instr[31:25], instr[11:7]};
      else
         fields.imm12 = instr[31:20];
      fields.illegal = ILLEGAL_CHK ? ~legal : 1'b0;
   end

endmodule

// File: rtl/instr_decode_stage.sv
// RV32I decode pipeline register with valid/ready handshake, stall and flush.
// Define DECODE_SKID_EN for a 2-entry skid buffer with registered IN_READY.
import decode_pkg::*;

module instr_decode_stage #(
   parameter int N           = 32,
   parameter bit ILLEGAL_CHK = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         FLUSH,
   input  logic         IN_VALID,
   output logic         IN_READY,
   input  logic [31:0]  INSTR,
   input  logic [N-1:0] IN_PC,
   output logic         OUT_VALID,
   input  logic         OUT_READY,
   output logic [N-1:0] PC,
   output logic [6:0]   OPCODE,
   output logic [4:0]   RD,
   output logic [2:0]   FUNCT3,
   output logic [4:0]   RS1,
   output logic [4:0]   RS2,
   output logic         FUNCT1,
   output logic [11:0]  IMM12,
   output logic [19:0]  U_IMM20,
   output logic         ILLEGAL
);

   decoded_fields_t dec;
   decoded_fields_t out_q;
   logic [N-1:0]    pc_q;
   logic            valid_q;
   logic            accept;

   decode_fields #(
      .ILLEGAL_CHK(ILLEGAL_CHK)
   ) u_fields (
      .instr (INSTR),
      .fields(dec)
   );

   assign accept = IN_VALID & IN_READY;

`ifdef DECODE_SKID_EN
   decoded_fields_t skid_f;
   logic [N-1:0]    skid_pc;
   logic            skid_v;
   logic            adv;

   // ready comes straight from the skid-occupancy flop
   assign IN_READY = ~skid_v;
   assign adv      = ~valid_q | OUT_READY;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         out_q   <= '0;
         pc_q    <= '0;
         skid_v  <= 1'b0;
         skid_f  <= '0;
         skid_pc <= '0;
      end else if (FLUSH) begin
         valid_q <= 1'b0;
         skid_v  <= 1'b0;
      end else if (adv) begin
         if (skid_v) begin
            out_q   <= skid_f;
            pc_q    <= skid_pc;
            valid_q <= 1'b1;
            skid_v  <= 1'b0;
         end else if (accept) begin
            out_q   <= dec;
            pc_q    <= IN_PC;
            valid_q <= 1'b1;
         end else begin
            valid_q <= 1'b0;
         end
      end else if (accept) begin
         skid_f  <= dec;
         skid_pc <= IN_PC;
         skid_v  <= 1'b1;
      end
   end
`else
   assign IN_READY = ~valid_q | OUT_READY;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         out_q   <= '0;
         pc_q    <= '0;
      end else if (FLUSH) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         out_q   <= dec;
         pc_q    <= IN_PC;
         valid_q <= 1'b1;
      end else if (OUT_READY) begin
         valid_q <= 1'b0;
      end
   end
`endif

   assign OUT_VALID = valid_q;
   assign PC        = pc_q;
   assign OPCODE    = out_q.opcode;
   assign RD        = out_q.rd;
   assign FUNCT3    = out_q.funct3;
   assign RS1       = out_q.rs1;
   assign RS2       = out_q.rs2;
   assign FUNCT1    = out_q.funct1;
   assign IMM12     = out_q.imm12;
   assign U_IMM20   = out_q.u_imm20;
   assign ILLEGAL   = out_q.illegal;

endmodule
